// File: rtl/pipe_arbiter.sv
// -----------------------------------------------------------------------------
// pipe_arbiter
//
// Shares one fixed-latency multiply-accumulate pipeline (pipe_C = A1*B1 + A2*B2)
// between two requesters. Each cycle at most one operand set is granted,
// using round-robin priority when both requesters contend. The grant is also
// gated by a per-requester credit, so every issued operation always has a
// free slot waiting in that requester's result FIFO.
// A tag {valid, id} travels alongside each operation. When the tag exits, the
// matching pipe_C value is steered into the FIFO of the requester that issued it.
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   reqN_valid / reqN_ready     operand handshake for requester N (ready is
//                               combinational from valid, credit and pointer)
//   reqN_a1/b1/a2/b2            operands of requester N
//   resN_valid / resN_ready     result handshake for requester N
//   resN_data                   head of requester N's result FIFO
//   pipe_A1/B1/A2/B2            registered operands to the shared pipeline
//   pipe_C                      pipeline result, LAT cycles after pipe_* operands
// -----------------------------------------------------------------------------
module pipe_arbiter #(
    parameter int W     = 32,
    parameter int LAT   = 2,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,

    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a1,
    input  logic [W-1:0] req0_b1,
    input  logic [W-1:0] req0_a2,
    input  logic [W-1:0] req0_b2,

    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a1,
    input  logic [W-1:0] req1_b1,
    input  logic [W-1:0] req1_a2,
    input  logic [W-1:0] req1_b2,

    output logic         res0_valid,
    input  logic         res0_ready,
    output logic [W-1:0] res0_data,

    output logic         res1_valid,
    input  logic         res1_ready,
    output logic [W-1:0] res1_data,

    output logic [W-1:0] pipe_A1,
    output logic [W-1:0] pipe_B1,
    output logic [W-1:0] pipe_A2,
    output logic [W-1:0] pipe_B2,
    input  logic [W-1:0] pipe_C
);

    localparam int CW = $clog2(DEPTH + 1);              // counts 0..DEPTH
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1; // FIFO index width
    localparam int NS = LAT + 1;                        // tag stages
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    typedef struct packed {
        logic [W-1:0] a1;
        logic [W-1:0] b1;
        logic [W-1:0] a2;
        logic [W-1:0] b2;
    } ops_t;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Per-requester views of the flat ports
    logic [1:0] req_valid;
    logic [1:0] res_ready;
    ops_t       req_ops [2];

    assign req_valid  = {req1_valid, req0_valid};
    assign res_ready  = {res1_ready, res0_ready};
    assign req_ops[0] = {req0_a1, req0_b1, req0_a2, req0_b2};
    assign req_ops[1] = {req1_a1, req1_b1, req1_a2, req1_b2};

    // State
    logic          rr_ptr_q,    rr_ptr_d;     // requester favoured on contention
    ops_t          ops_q,       ops_d;
    logic [NS-1:0] tag_valid_q, tag_valid_d;
    logic [NS-1:0] tag_id_q,    tag_id_d;
    logic [CW-1:0] count_q    [2];
    logic [CW-1:0] count_d    [2];
    logic [CW-1:0] inflight_q [2];
    logic [CW-1:0] inflight_d [2];
    logic [PW-1:0] wr_ptr_q   [2];
    logic [PW-1:0] wr_ptr_d   [2];
    logic [PW-1:0] rd_ptr_q   [2];
    logic [PW-1:0] rd_ptr_d   [2];
    logic [W-1:0]  mem_q      [2][DEPTH];

    logic [1:0] eligible;
    logic [1:0] grant;
    logic [1:0] push;
    logic [1:0] pop;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        eligible = '0;
        for (int n = 0; n < 2; n++) begin
            // Credit > 0 means stored plus in-flight results leave a free slot.
            eligible[n] = req_valid[n] &&
                          (({1'b0, count_q[n]} + {1'b0, inflight_q[n]}) < DEPTH_W);
        end

        grant    = eligible;
        rr_ptr_d = rr_ptr_q;
        if (&eligible) begin
            grant    = rr_ptr_q ? 2'b10 : 2'b01;
            rr_ptr_d = ~rr_ptr_q;
        end

        // Nothing is accepted while reset is asserted.
        if (!rst_n) begin
            grant = '0;
        end
    end

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    // ------------------------------------------------------------------
    // Operand register and tag shift chain
    // ------------------------------------------------------------------
    always_comb begin
        ops_d = ops_q;
        if (grant[1]) begin
            ops_d = req_ops[1];
        end else if (grant[0]) begin
            ops_d = req_ops[0];
        end

        tag_valid_d    = tag_valid_q;
        tag_id_d       = tag_id_q;
        tag_valid_d[0] = |grant;
        tag_id_d[0]    = grant[1];
        for (int i = 1; i < NS; i++) begin
            tag_valid_d[i] = tag_valid_q[i-1];
            tag_id_d[i]    = tag_id_q[i-1];
        end
    end

    assign pipe_A1 = ops_q.a1;
    assign pipe_B1 = ops_q.b1;
    assign pipe_A2 = ops_q.a2;
    assign pipe_B2 = ops_q.b2;

    // ------------------------------------------------------------------
    // Result FIFOs and credit bookkeeping
    // ------------------------------------------------------------------
    always_comb begin
        push = '0;
        pop  = '0;
        for (int n = 0; n < 2; n++) begin
            // The exiting tag lines up with pipe_C in this cycle.
            push[n] = tag_valid_q[NS-1] && (tag_id_q[NS-1] == n[0]);
            pop[n]  = (count_q[n] != '0) && res_ready[n];

            count_d[n] = count_q[n];
            if (push[n] && !pop[n]) begin
                count_d[n] = count_q[n] + CW'(1);
            end else if (pop[n] && !push[n]) begin
                count_d[n] = count_q[n] - CW'(1);
            end

            inflight_d[n] = inflight_q[n];
            if (grant[n] && !push[n]) begin
                inflight_d[n] = inflight_q[n] + CW'(1);
            end else if (push[n] && !grant[n]) begin
                inflight_d[n] = inflight_q[n] - CW'(1);
            end

            wr_ptr_d[n] = push[n] ? ptr_inc(wr_ptr_q[n]) : wr_ptr_q[n];
            rd_ptr_d[n] = pop[n]  ? ptr_inc(rd_ptr_q[n]) : rd_ptr_q[n];
        end
    end

    assign res0_valid = rst_n && (count_q[0] != '0);
    assign res1_valid = rst_n && (count_q[1] != '0);
    assign res0_data  = mem_q[0][rd_ptr_q[0]];
    assign res1_data  = mem_q[1][rd_ptr_q[1]];

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q    <= 1'b0;
            ops_q       <= '0;
            tag_valid_q <= '0;
            tag_id_q    <= '0;
            for (int n = 0; n < 2; n++) begin
                count_q[n]    <= '0;
                inflight_q[n] <= '0;
                wr_ptr_q[n]   <= '0;
                rd_ptr_q[n]   <= '0;
            end
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            ops_q       <= ops_d;
            tag_valid_q <= tag_valid_d;
            tag_id_q    <= tag_id_d;
            for (int n = 0; n < 2; n++) begin
                count_q[n]    <= count_d[n];
                inflight_q[n] <= inflight_d[n];
                wr_ptr_q[n]   <= wr_ptr_d[n];
                rd_ptr_q[n]   <= rd_ptr_d[n];
            end
        end
    end

    // NOTE: FIFO storage is deliberately not reset; count and pointers alone
    // decide which entries are live, so stale contents are never visible.
    always_ff @(posedge clk) begin
        for (int n = 0; n < 2; n++) begin
            if (push[n]) begin
                mem_q[n][wr_ptr_q[n]] <= pipe_C;
            end
        end
    end

endmodule

// File: tb/tb_pipe_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pipe_arbiter
//
// Directed bench for pipe_arbiter at default parameters. It includes a
// two-stage model of the shared multiply-accumulate pipeline, so pipe_C holds
// A1*B1 + A2*B2 exactly LAT=2 cycles after the pipe_* operands. Inputs change
// 1 time unit after each rising edge. Outputs are sampled 1 unit later.
// -----------------------------------------------------------------------------
module tb_pipe_arbiter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0] req0_a1, req0_b1, req0_a2, req0_b2;
    logic [W-1:0] req1_a1, req1_b1, req1_a2, req1_b2;
    logic         res0_valid, res0_ready, res1_valid, res1_ready;
    logic [W-1:0] res0_data, res1_data;
    logic [W-1:0] pipe_A1, pipe_B1, pipe_A2, pipe_B2, pipe_C;
    logic [W-1:0] mac_s1;

    int vectors     = 0;
    int miscompares = 0;
    int grants;

    always #5 clk = ~clk;

    pipe_arbiter #(.W(W), .LAT(2), .DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a1    (req0_a1),
        .req0_b1    (req0_b1),
        .req0_a2    (req0_a2),
        .req0_b2    (req0_b2),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a1    (req1_a1),
        .req1_b1    (req1_b1),
        .req1_a2    (req1_a2),
        .req1_b2    (req1_b2),
        .res0_valid (res0_valid),
        .res0_ready (res0_ready),
        .res0_data  (res0_data),
        .res1_valid (res1_valid),
        .res1_ready (res1_ready),
        .res1_data  (res1_data),
        .pipe_A1    (pipe_A1),
        .pipe_B1    (pipe_B1),
        .pipe_A2    (pipe_A2),
        .pipe_B2    (pipe_B2),
        .pipe_C     (pipe_C)
    );

    // Shared pipeline model: two register stages, W-bit wraparound arithmetic.
    always @(posedge clk) begin
        mac_s1 <= pipe_A1 * pipe_B1 + pipe_A2 * pipe_B2;
        pipe_C <= mac_s1;
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic v, input logic [W-1:0] a1, b1, a2, b2);
        req0_valid = v; req0_a1 = a1; req0_b1 = b1; req0_a2 = a2; req0_b2 = b2;
    endtask

    task automatic drive1(input logic v, input logic [W-1:0] a1, b1, a2, b2);
        req1_valid = v; req1_a1 = a1; req1_b1 = b1; req1_a2 = a2; req1_b2 = b2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---- Reset: outputs held inactive even with valid requests ----
        rst_n      = 1'b0;
        res0_ready = 1'b0;
        res1_ready = 1'b0;
        drive0(1'b1, 1, 1, 1, 1);
        drive1(1'b1, 1, 1, 1, 1);
        cyc();
        cyc();
        #1;
        chk1("rst_req0_ready", req0_ready, 1'b0);
        chk1("rst_req1_ready", req1_ready, 1'b0);
        chk1("rst_res0_valid", res0_valid, 1'b0);
        chk1("rst_res1_valid", res1_valid, 1'b0);
        chk ("rst_pipe_A1",    pipe_A1,    0);
        chk ("rst_pipe_B2",    pipe_B2,    0);
        rst_n      = 1'b1;
        res0_ready = 1'b1;
        res1_ready = 1'b1;
        drive0(1'b0, 0, 0, 0, 0);
        drive1(1'b0, 0, 0, 0, 0);
        cyc();

        // ---- Single request (0,1,2,3) -> 6, four cycles after grant ----
        drive0(1'b1, 0, 1, 2, 3);
        #1;
        chk1("a_ready0", req0_ready, 1'b1);
        chk1("a_ready1", req1_ready, 1'b0);
        cyc();
        req0_valid = 1'b0;
        #1;
        chk("a_pipe_A1", pipe_A1, 0);
        chk("a_pipe_B1", pipe_B1, 1);
        chk("a_pipe_A2", pipe_A2, 2);
        chk("a_pipe_B2", pipe_B2, 3);
        chk1("a_res0_early1", res0_valid, 1'b0);
        for (int i = 2; i <= 3; i++) begin
            cyc();
            #1;
            chk1("a_res0_early", res0_valid, 1'b0);
        end
        cyc();
        #1;
        chk1("a_res0_valid", res0_valid, 1'b1);
        chk ("a_res0_data",  res0_data,  6);
        cyc();
        #1;
        chk1("a_res0_drained", res0_valid, 1'b0);

        // ---- Both valid every cycle: grants alternate 0,1,0,1 ----
        for (int k = 0; k < 4; k++) begin
            drive0(1'b1, 4, 2, 1, 0);
            drive1(1'b1, 0, 1, 2, 3);
            #1;
            chk1("b_ready0", req0_ready, (k % 2) == 0);
            chk1("b_ready1", req1_ready, (k % 2) == 1);
            cyc();
        end
        drive0(1'b0, 0, 0, 0, 0);
        drive1(1'b0, 0, 0, 0, 0);
        for (int k = 4; k < 8; k++) begin
            #1;
            chk1("b_res0_valid", res0_valid, (k % 2) == 0);
            chk1("b_res1_valid", res1_valid, (k % 2) == 1);
            if ((k % 2) == 0) chk("b_res0_data", res0_data, 8);
            else              chk("b_res1_data", res1_data, 6);
            cyc();
        end

        // ---- Truncation: all-ones operands -> 2 ----
        drive0(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        #1;
        chk1("c_ready0", req0_ready, 1'b1);
        cyc();
        req0_valid = 1'b0;
        cyc();
        cyc();
        cyc();
        #1;
        chk1("c_res0_valid", res0_valid, 1'b1);
        chk ("c_res0_data",  res0_data,  32'h0000_0002);
        cyc();

        // ---- Credit limit on requester 1 with its results stalled ----
        res1_ready = 1'b0;
        grants     = 0;
        for (int k = 0; k < 10; k++) begin
            drive1(1'b1, k + 1, 1, 0, 0);
            #1;
            if (req1_ready) grants++;
            cyc();
        end
        req1_a1 = 99;
        drive0(1'b1, 0, 1, 2, 3);
        #1;
        chk ("d_grants_full",   grants,     4);
        chk1("d_ready1_full",   req1_ready, 1'b0);
        chk1("d_ready0_indep",  req0_ready, 1'b1);
        chk1("d_res1_valid",    res1_valid, 1'b1);
        chk ("d_res1_head1",    res1_data,  1);
        res1_ready = 1'b1;                      // one pop
        cyc();
        res1_ready = 1'b0;
        req0_valid = 1'b0;
        req1_a1    = 5;
        grants     = 0;
        for (int j = 0; j < 6; j++) begin
            #1;
            if (req1_ready) grants++;
            if (j == 3) begin
                chk1("d_res0_valid", res0_valid, 1'b1);
                chk ("d_res0_data",  res0_data,  6);
            end
            cyc();
        end
        req1_valid = 1'b0;
        #1;
        chk("d_grants_after_pop", grants,    1);
        chk("d_res1_head2",       res1_data, 2);
        res1_ready = 1'b1;
        cyc();
        #1;
        chk("d_res1_head3", res1_data, 3);
        cyc();
        res1_ready = 1'b0;                      // FIFO 1 now holds 4,5
        drive1(1'b1, 6, 1, 0, 0);
        #1;
        chk ("d_res1_head4", res1_data,  4);
        chk1("d_ready1_6",   req1_ready, 1'b1);
        cyc();
        req1_valid = 1'b0;
        cyc();
        cyc();
        res1_ready = 1'b1;                      // pop 4 as 6 is pushed
        #1;
        chk("d_pp_head4", res1_data, 4);
        cyc();
        #1;
        chk1("d_pp_valid5", res1_valid, 1'b1);
        chk ("d_pp_head5",  res1_data,  5);
        cyc();
        #1;
        chk1("d_pp_valid6", res1_valid, 1'b1);
        chk ("d_pp_head6",  res1_data,  6);
        cyc();
        #1;
        chk1("d_pp_empty",  res1_valid, 1'b0);

        // ---- Reset with two results in flight ----
        res0_ready = 1'b1;
        drive0(1'b1, 1, 1, 1, 1);
        drive1(1'b1, 2, 2, 2, 2);
        #1;
        chk1("e_ready0", req0_ready, 1'b1);
        chk1("e_ready1", req1_ready, 1'b0);
        cyc();
        #1;
        chk1("e_ready1b", req1_ready, 1'b1);
        chk1("e_ready0b", req0_ready, 1'b0);
        cyc();
        req1_valid = 1'b0;
        rst_n      = 1'b0;
        #1;
        chk1("e_rst_ready0", req0_ready, 1'b0);
        cyc();
        rst_n      = 1'b1;
        req0_valid = 1'b0;
        #1;
        chk("e_pipe_A1", pipe_A1, 0);
        chk("e_pipe_B1", pipe_B1, 0);
        chk("e_pipe_A2", pipe_A2, 0);
        chk("e_pipe_B2", pipe_B2, 0);
        for (int j = 0; j < 6; j++) begin
            chk1("e_res0_quiet", res0_valid, 1'b0);
            chk1("e_res1_quiet", res1_valid, 1'b0);
            cyc();
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
